// File: rtl/zdos_nmi_ctrl_if.sv
// Bundle of the Z80 snoop bus, pager DOS strobes and NMI controls around zdos_nmi_ctrl.
// The controller takes the slave modport; the surrounding system drives through master.
interface zdos_nmi_ctrl_if;
  logic        zpos;
  logic        zneg;
  logic [15:0] za;
  logic [7:0]  zd;
  logic        m1_n;
  logic        mreq_n;
  logic        rd_n;
  logic [3:0]  dos_turn_on;
  logic [3:0]  dos_turn_off;
  logic        nmi_btn;
  logic        clr_nmi;
  logic        dos;
  logic        in_nmi;
  logic        nmi_n;
  logic [1:0]  nmi_state;

  modport master (
    output zpos, zneg, za, zd, m1_n, mreq_n, rd_n,
    output dos_turn_on, dos_turn_off, nmi_btn, clr_nmi,
    input  dos, in_nmi, nmi_n, nmi_state
  );

  modport slave (
    input  zpos, zneg, za, zd, m1_n, mreq_n, rd_n,
    input  dos_turn_on, dos_turn_off, nmi_btn, clr_nmi,
    output dos, in_nmi, nmi_n, nmi_state
  );
endinterface

// File: rtl/zdos_nmi_ctrl.sv
// DOS flag merge and NMI request/acknowledge/exit sequencer for the ATM pagers.
// Define ZDOS_RETN_DETECT_EN to build opcode snooping and the RETN exit path.
module zdos_nmi_ctrl #(
  parameter int NMI_TMO_W = 16
) (
  input logic            fclk,
  input logic            rst,
  zdos_nmi_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_EXIT   = 2'd3
  } nmi_state_e;

  nmi_state_e           state;
  logic [NMI_TMO_W-1:0] tmo_cnt;
  logic                 dos_q;
  logic                 in_nmi_q;
  logic                 nmi_n_q;
  logic                 btn_s1, btn_s2, btn_s3, btn_rise;
  logic                 m1_n_reg, mreq_n_reg;
  logic                 fetch_start;
  logic                 enter_active;
  logic                 retn;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      dos_q <= 1'b0;
    end else if (|bus.dos_turn_on) begin
      dos_q <= 1'b1;
    end else if (|bus.dos_turn_off) begin
      dos_q <= 1'b0;
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_s3   <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      btn_s1   <= bus.nmi_btn;
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      btn_rise <= btn_s2 & ~btn_s3;
    end
  end

  // Bus line copies reset to their inactive (high) level so no phantom fetch is seen.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      m1_n_reg   <= 1'b1;
      mreq_n_reg <= 1'b1;
    end else begin
      if (bus.zpos) m1_n_reg   <= bus.m1_n;
      if (bus.zneg) mreq_n_reg <= bus.mreq_n;
    end
  end

  assign fetch_start  = bus.zneg & ~m1_n_reg & ~bus.mreq_n & mreq_n_reg;
  assign enter_active = (state == ST_REQ) && fetch_start && (bus.za == 16'h0066);

`ifdef ZDOS_RETN_DETECT_EN
  logic [7:0] opcode;
  logic       ed_prefix;
  logic       fetch_end;

  assign fetch_end = bus.zpos & bus.m1_n & ~m1_n_reg;
  assign retn      = fetch_end & ed_prefix & (opcode == 8'h45);

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      opcode    <= 8'h00;
      ed_prefix <= 1'b0;
    end else begin
      if (~bus.m1_n & ~bus.mreq_n & ~bus.rd_n) opcode <= bus.zd;
      // A stale ED fetched while still in REQ must not pair with the handler's first opcode.
      if (enter_active)   ed_prefix <= 1'b0;
      else if (fetch_end) ed_prefix <= (opcode == 8'hED);
    end
  end
`else
  assign retn = 1'b0;
`endif

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      nmi_n_q  <= 1'b1;
      in_nmi_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_rise) begin
            state   <= ST_REQ;
            tmo_cnt <= '0;
            nmi_n_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (enter_active) begin
            state    <= ST_ACTIVE;
            nmi_n_q  <= 1'b1;
            in_nmi_q <= 1'b1;
          end else if (&tmo_cnt) begin
            state   <= ST_IDLE;
            nmi_n_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (bus.clr_nmi) begin
            state    <= ST_IDLE;
            in_nmi_q <= 1'b0;
          end else if (retn) begin
            state <= ST_EXIT;
          end
        end
        ST_EXIT: begin
          // First fetch after RETN is the return target; the stack pops are already done.
          if (bus.clr_nmi || fetch_start) begin
            state    <= ST_IDLE;
            in_nmi_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dos       = dos_q;
  assign bus.in_nmi    = in_nmi_q;
  assign bus.nmi_n     = nmi_n_q;
  assign bus.nmi_state = state;

endmodule

// File: tb/tb_zdos_nmi_ctrl.sv
// Self-checking bench for zdos_nmi_ctrl: DOS vector table, randomized DOS and NMI runs
// against a cycle-count model, and hand sequences for entry, RETN, timeout, clr_nmi, reset.
module tb_zdos_nmi_ctrl;

  localparam int TMO_CYCLES = 16;

`ifdef ZDOS_RETN_DETECT_EN
  localparam bit RETN_EN = 1'b1;
`else
  localparam bit RETN_EN = 1'b0;
`endif

  logic fclk;
  logic rst;

  zdos_nmi_ctrl_if bus ();

  zdos_nmi_ctrl #(.NMI_TMO_W(4)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] on;
    logic [3:0] off;
    logic       exp_dos;
  } dos_vec_t;

  dos_vec_t dv[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
    bus.zpos         = 1'b0;
    bus.zneg         = 1'b0;
    bus.clr_nmi      = 1'b0;
    bus.dos_turn_on  = 4'h0;
    bus.dos_turn_off = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // T1 rise (M1 latched) then T1 fall with MREQ low: the second tick carries fetch_start.
  task automatic fetch_head(input logic [15:0] a, input logic [7:0] op);
    bus.za   = a;
    bus.m1_n = 1'b0;
    bus.zpos = 1'b1;
    tick();
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    bus.zd     = op;
    bus.zneg   = 1'b1;
    tick();
  endtask

  // T2, then T3 rise with M1 released (fetch_end), then T3 fall relatching MREQ high.
  task automatic fetch_tail();
    tick();
    bus.m1_n   = 1'b1;
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.zpos   = 1'b1;
    tick();
    bus.zneg = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [15:0] a, input logic [7:0] op);
    fetch_head(a, op);
    fetch_tail();
  endtask

  // Button edge: nmi_n must still be high after 3 edges and low after the 4th.
  task automatic press();
    bus.nmi_btn = 1'b1;
    idle(3);
    check("press_nmi_n_cycle3", bus.nmi_n, 1);
    tick();
    check("press_nmi_n_cycle4", bus.nmi_n, 0);
    check("press_state_req", bus.nmi_state, 1);
    bus.nmi_btn = 1'b0;
  endtask

  task automatic clear_nmi();
    bus.clr_nmi = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r_on, r_off;
    logic       dos_model;
    int         bad;

    rst              = 1'b1;
    bus.zpos         = 1'b0;
    bus.zneg         = 1'b0;
    bus.za           = 16'h0000;
    bus.zd           = 8'h00;
    bus.m1_n         = 1'b1;
    bus.mreq_n       = 1'b1;
    bus.rd_n         = 1'b1;
    bus.dos_turn_on  = 4'h0;
    bus.dos_turn_off = 4'h0;
    bus.nmi_btn      = 1'b0;
    bus.clr_nmi      = 1'b0;

    dv[0] = '{4'b0010, 4'b0000, 1'b1};
    dv[1] = '{4'b0001, 4'b1000, 1'b1};
    dv[2] = '{4'b0000, 4'b0100, 1'b0};
    dv[3] = '{4'b0000, 4'b0000, 1'b0};
    dv[4] = '{4'b1000, 4'b1111, 1'b1};
    dv[5] = '{4'b0000, 4'b0000, 1'b1};
    dv[6] = '{4'b0000, 4'b0001, 1'b0};

    idle(2);
    check("reset_dos", bus.dos, 0);
    check("reset_in_nmi", bus.in_nmi, 0);
    check("reset_nmi_n", bus.nmi_n, 1);
    check("reset_state", bus.nmi_state, 0);
    rst = 1'b0;
    idle(2);

    // DOS merge table
    for (int i = 0; i < 7; i++) begin
      bus.dos_turn_on  = dv[i].on;
      bus.dos_turn_off = dv[i].off;
      tick();
      check($sformatf("dos_vec%0d", i), bus.dos, dv[i].exp_dos);
    end

    // Randomized DOS strobes against the on-wins rule
    dos_model = bus.dos;
    for (int i = 0; i < 64; i++) begin
      r_on  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      r_off = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      if (r_on != 4'h0)       dos_model = 1'b1;
      else if (r_off != 4'h0) dos_model = 1'b0;
      bus.dos_turn_on  = r_on;
      bus.dos_turn_off = r_off;
      tick();
      check("dos_random", bus.dos, dos_model);
    end
    bus.dos_turn_off = 4'hF;
    tick();

    // Entry: non-0x0066 fetch ignored, 0x0066 acknowledges one fclk after fetch_start
    idle(4);
    press();
    fetch(16'h0038, 8'hFF);
    check("fetch38_state", bus.nmi_state, 1);
    check("fetch38_nmi_n", bus.nmi_n, 0);
    fetch_head(16'h0066, 8'h00);
    check("entry_in_nmi", bus.in_nmi, 1);
    check("entry_nmi_n", bus.nmi_n, 1);
    check("entry_state", bus.nmi_state, 2);
    fetch_tail();

    // RETN: EXIT after the 0x45 fetch_end, IDLE at the next fetch_start
    fetch(16'h0067, 8'hED);
    fetch(16'h0069, 8'h45);
    check("retn_state", bus.nmi_state, RETN_EN ? 3 : 2);
    check("retn_in_nmi", bus.in_nmi, 1);
    fetch_head(16'h1234, 8'h00);
    check("exit_in_nmi", bus.in_nmi, RETN_EN ? 0 : 1);
    check("exit_state", bus.nmi_state, RETN_EN ? 0 : 2);
    fetch_tail();
    clear_nmi();
    check("after_exit_state", bus.nmi_state, 0);

    // ED, 00, 45 is not RETN; clr_nmi then leaves ACTIVE in one fclk
    idle(4);
    press();
    fetch(16'h0066, 8'h00);
    fetch(16'h0067, 8'hED);
    fetch(16'h0069, 8'h00);
    fetch(16'h006A, 8'h45);
    check("broken_retn_state", bus.nmi_state, 2);
    clear_nmi();
    check("clr_active_state", bus.nmi_state, 0);
    check("clr_active_in_nmi", bus.in_nmi, 0);
    clear_nmi();
    check("clr_idle_state", bus.nmi_state, 0);
    check("clr_idle_nmi_n", bus.nmi_n, 1);

    // clr_nmi in REQ ignored; an ED fetched during REQ does not prefix the handler's 0x45
    idle(4);
    press();
    clear_nmi();
    check("clr_req_state", bus.nmi_state, 1);
    check("clr_req_nmi_n", bus.nmi_n, 0);
    fetch(16'h0040, 8'hED);
    fetch(16'h0066, 8'h45);
    check("prefix_cleared_state", bus.nmi_state, 2);
    clear_nmi();

    // Timeout: nmi_n low for exactly 16 cycles, second press in REQ ignored, no in_nmi pulse
    idle(4);
    press();
    bad = 0;
    for (int k = 1; k < TMO_CYCLES; k++) begin
      if (k == 4) bus.nmi_btn = 1'b1;
      if (k == 9) bus.nmi_btn = 1'b0;
      tick();
      if (bus.nmi_n !== 1'b0 || bus.in_nmi !== 1'b0) bad++;
    end
    check("tmo_req_hold", bad, 0);
    tick();
    check("tmo_nmi_n", bus.nmi_n, 1);
    check("tmo_state", bus.nmi_state, 0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.nmi_state !== 2'd0 || bus.in_nmi !== 1'b0) bad++;
    end
    check("tmo_stays_idle", bad, 0);

    // Randomized fetch delay around the timeout boundary; entry iff fetch_start lands by cycle 16
    for (int it = 0; it < 12; it++) begin
      int w;
      bit entered;
      int exp_state;
      idle(4);
      press();
      w       = (it < 2) ? 14 + it : $urandom_range(10, 18);
      entered = (w + 2 <= TMO_CYCLES);
      bad = 0;
      for (int k = 0; k < w; k++) begin
        tick();
        if (bus.in_nmi !== 1'b0) bad++;
      end
      check("rand_wait_in_nmi", bad, 0);
      check("rand_nmi_n_before_fetch", bus.nmi_n, (w < TMO_CYCLES) ? 0 : 1);
      fetch_head(16'h0066, 8'h00);
      check("rand_entry_state", bus.nmi_state, entered ? 2 : 0);
      check("rand_entry_in_nmi", bus.in_nmi, entered);
      fetch_tail();
      if ($urandom_range(0, 1) == 1) begin
        fetch(16'h0067, 8'hED);
        fetch(16'h0068, 8'h45);
        exp_state = entered ? (RETN_EN ? 3 : 2) : 0;
        check("rand_retn_state", bus.nmi_state, exp_state);
      end
      clear_nmi();
      check("rand_final_state", bus.nmi_state, 0);
      check("rand_final_in_nmi", bus.in_nmi, 0);
    end

    // Async reset mid-REQ, between clock edges, then a clean restart
    bus.dos_turn_on = 4'b0100;
    tick();
    check("pre_reset_dos", bus.dos, 1);
    idle(3);
    press();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_nmi_n", bus.nmi_n, 1);
    check("async_rst_in_nmi", bus.in_nmi, 0);
    check("async_rst_dos", bus.dos, 0);
    check("async_rst_state", bus.nmi_state, 0);
    tick();
    rst = 1'b0;
    idle(2);
    press();
    fetch_head(16'h0066, 8'h00);
    check("restart_in_nmi", bus.in_nmi, 1);
    fetch_tail();
    clear_nmi();
    check("restart_exit_state", bus.nmi_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zdos_nmi_ctrl.md
# zdos_nmi_ctrl

DOS-state and NMI-entry controller sitting directly upstream of the four per-window ATM pagers. It merges their `dos_turn_on`/`dos_turn_off` strobes into the single `dos` flag they consume. It also runs the NMI request/acknowledge/exit sequence that drives the pagers' `in_nmi` input and the Z80 `/NMI` pin. Opcode fetches on the Z80 bus are snooped to detect entry at 0x0066 and exit via RETN.

## Interface
- `NMI_TMO_W`, default 16: width of the NMI acknowledge timeout counter; timeout is 2^`NMI_TMO_W` fclk cycles.
- `fclk  in  1`  system clock.
- `rst  in  1`  asynchronous, active-high reset.
- `zpos  in  1`  Z80 clock rising-edge strobe, one fclk wide.
- `zneg  in  1`  Z80 clock falling-edge strobe, one fclk wide.
- `za  in  16`  Z80 address bus.
- `zd  in  8`  Z80 data bus, snooped during opcode reads.
- `m1_n, mreq_n, rd_n  in  1 each`  Z80 control lines.
- `dos_turn_on  in  4`  per-window DOS-on strobes from pagers, index = window.
- `dos_turn_off  in  4`  per-window DOS-off strobes from pagers.
- `nmi_btn  in  1`  asynchronous NMI button level, active-high.
- `clr_nmi  in  1`  one-fclk strobe from the port decoder; forces NMI exit.
- `dos  out  1`  DOS state to all pagers.
- `in_nmi  out  1`  NMI-in-progress flag to all pagers.
- `nmi_n  out  1`  Z80 `/NMI` drive, active-low.
- `nmi_state  out  2`  FSM state for the readback port: 0=IDLE, 1=REQ, 2=ACTIVE, 3=EXIT.

## Operation
- **Reset values:** `dos`=0, `in_nmi`=0, `nmi_n`=1, state IDLE, all sync/edge/prefix registers cleared, timeout counter 0.
- **DOS flag:**
  - Any bit of `dos_turn_on` set: `dos` goes to 1.
  - Otherwise, any bit of `dos_turn_off` set: `dos` goes to 0.
  - On and off in the same cycle: on wins.
- **Button path:** `nmi_btn` passes a 2-flop synchroniser, then a rising-edge detector. The resulting one-cycle `btn_rise` is the only NMI request source.
- **Bus tracking:**
  - `m1_n_reg` is latched on `zpos`; `mreq_n_reg` is latched on `zneg`.
  - fetch_start = `zneg` & !`m1_n_reg` & !`mreq_n` & `mreq_n_reg`.
  - The opcode register captures `zd` every fclk while !`m1_n` & !`mreq_n` & !`rd_n`.
  - fetch_end = `zpos` & `m1_n` & !`m1_n_reg`. At fetch_end the opcode register holds the fetched opcode.
- **FSM:**
  - IDLE: `nmi_n`=1, `in_nmi`=0. On `btn_rise`, go to REQ and zero the counter.
  - REQ: `nmi_n`=0.
    - fetch_start with `za`==0x0066: go to ACTIVE.
    - Else, if the counter reaches all-ones: go to IDLE (timeout).
    - Counter increments every fclk.
    - `btn_rise` is ignored.
  - ACTIVE: `nmi_n`=1, `in_nmi`=1.
    - `clr_nmi`: go to IDLE.
    - RETN detected (see below): go to EXIT.
  - EXIT: `in_nmi`=1. On the next fetch_start (first opcode after the stack pops), go to IDLE. `clr_nmi` also goes to IDLE.
- **RETN detection (when compiled in):**
  - At each fetch_end, the prefix flag is set if the opcode is 0xED, and cleared otherwise.
  - RETN is detected at a fetch_end with opcode 0x45 while the prefix flag is set.
  - The prefix flag is cleared on entry to ACTIVE.
- **`clr_nmi` in IDLE or REQ:** no effect.
- **Reset mid-sequence:** immediately IDLE, `nmi_n`=1, `in_nmi`=0.

## Timing
- `dos` changes exactly one fclk after the strobe cycle.
- `btn_rise` asserts 3 fclk after the `nmi_btn` edge (2 sync flops plus 1 edge flop). `nmi_n` falls on the following clock edge.
- `in_nmi` rises one fclk after the qualifying fetch_start, during the same M1 cycle. Page FF is therefore selected before the opcode read at 0x0066 completes.
- `in_nmi` falls one fclk after the exit condition: the EXIT-state fetch_start, or `clr_nmi`.
- A timeout in REQ returns `nmi_n` to 1 one fclk after the counter reaches all-ones. No `in_nmi` pulse occurs.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ZDOS_RETN_DETECT_EN` defined:
  - Opcode snooping and RETN detection are built.
  - ACTIVE exits via RETN (through EXIT) or via `clr_nmi`.
- `ZDOS_RETN_DETECT_EN` undefined:
  - No opcode register and no prefix flag.
  - The EXIT state is unreachable.
  - ACTIVE leaves only on `clr_nmi`, going straight to IDLE.
  - `nmi_state` never reads 3.

## Test plan
- **DOS merge:** `dos_turn_on`=4'b0010 for 1 cycle -> `dos`=1 next cycle. Then on=4'b0001 and off=4'b1000 together -> `dos` stays 1. Then off=4'b0100 -> `dos`=0.
- **NMI entry:**
  - `nmi_btn` 0->1 -> `nmi_n`=0 at cycle 4, `nmi_state`=1.
  - A fetch_start at `za`=0x0038 changes nothing.
  - A fetch_start at 0x0066 -> `in_nmi`=1 and `nmi_n`=1 one fclk later.
- **RETN exit (macro on):**
  - In ACTIVE, fetch opcodes 0xED then 0x45 -> `nmi_state`=3 after the second fetch_end.
  - The next fetch_start -> `in_nmi`=0.
  - The sequence 0xED, 0x00, 0x45 -> stays ACTIVE.
- **Timeout:** with `NMI_TMO_W`=4, press the button and issue no fetch at 0x0066 -> `nmi_n` returns to 1 after 16 cycles in REQ, and `in_nmi` stays 0 throughout.
- **`clr_nmi`:** in ACTIVE -> IDLE next cycle. Repeat with the macro undefined: opcodes 0xED, 0x45 leave the state ACTIVE.
- **Async reset:** assert `rst` mid-REQ, between clock edges -> `nmi_n`=1, `in_nmi`=0, `dos`=0 immediately. After release, one button press restarts the sequence normally.
